// File: rtl/up_router_pkg.sv
// Shared definitions for the uP register router: FSM encoding and width helpers.
package up_router_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WR_WAIT = 3'd2,
    RESP    = 3'd3,
    HOLD    = 3'd4
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  // Slave index needs at least one bit even with a single slave.
  function automatic int sel_width(input int num_slaves);
    return (num_slaves > 1) ? clog2(num_slaves) : 1;
  endfunction

  function automatic int cnt_width(input int timeout_cycles);
    return clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/up_router_decode.sv
// Address window decode: slave index, in-range flag and window-local address.
module up_router_decode #(
  parameter int ADDRESS_WIDTH   = 16,
  parameter int SLAVE_ADDR_BITS = 8,
  parameter int NUM_SLAVES      = 4,
  parameter int SEL_WIDTH       = 2
) (
  input  logic [ADDRESS_WIDTH-1:0] addr,
  output logic [SEL_WIDTH-1:0]     idx,
  output logic                     valid,
  output logic [ADDRESS_WIDTH-1:0] local_addr
);

  localparam int IDX_W = ADDRESS_WIDTH - SLAVE_ADDR_BITS;

  logic [IDX_W-1:0] full_idx;

  always_comb begin
    full_idx   = addr[ADDRESS_WIDTH-1:SLAVE_ADDR_BITS];
    // Compare the whole upper field so aliases above NUM_SLAVES never decode.
    valid      = (32'(full_idx) < 32'(NUM_SLAVES));
    idx        = full_idx[SEL_WIDTH-1:0];
    local_addr = ADDRESS_WIDTH'(addr[SLAVE_ADDR_BITS-1:0]);
  end

endmodule

// File: rtl/up_router.sv
// Routes one uP register bus to NUM_SLAVES banks by address window, one access at a time,
// self-acking decode errors and slave timeouts so the upstream bus never hangs.
module up_router
  import up_router_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 16,
  parameter int BUS_WIDTH       = 4,
  parameter int NUM_SLAVES      = 4,
  parameter int SLAVE_ADDR_BITS = 8,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter logic [BUS_WIDTH*8-1:0] ERROR_DATA = 'hDEADBEEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               up_rreq,
  output logic                               up_rack,
  input  logic [ADDRESS_WIDTH-1:0]           up_raddr,
  output logic [BUS_WIDTH*8-1:0]             up_rdata,
  input  logic                               up_wreq,
  output logic                               up_wack,
  input  logic [ADDRESS_WIDTH-1:0]           up_waddr,
  input  logic [BUS_WIDTH*8-1:0]             up_wdata,
  output logic [NUM_SLAVES-1:0]              m_up_rreq,
  input  logic [NUM_SLAVES-1:0]              m_up_rack,
  output logic [ADDRESS_WIDTH-1:0]           m_up_raddr,
  input  logic [NUM_SLAVES*BUS_WIDTH*8-1:0]  m_up_rdata,
  output logic [NUM_SLAVES-1:0]              m_up_wreq,
  input  logic [NUM_SLAVES-1:0]              m_up_wack,
  output logic [ADDRESS_WIDTH-1:0]           m_up_waddr,
  output logic [BUS_WIDTH*8-1:0]             m_up_wdata,
  output logic                               err
);

  localparam int DW        = BUS_WIDTH * 8;
  localparam int SEL_WIDTH = sel_width(NUM_SLAVES);
  localparam int CNT_WIDTH = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                   state;
  logic                     is_rd;
  logic [SEL_WIDTH-1:0]     sel;
  logic [CNT_WIDTH-1:0]     cnt;

  logic [ADDRESS_WIDTH-1:0] dec_addr;
  logic [SEL_WIDTH-1:0]     dec_idx;
  logic                     dec_valid;
  logic [ADDRESS_WIDTH-1:0] dec_local;

  logic                     sel_rack;
  logic                     sel_wack;
  logic [DW-1:0]            sel_rdata;
  logic                     timeout;

  // Reads win when both requests are up, so decode the read address first.
  assign dec_addr = up_rreq ? up_raddr : up_waddr;

  up_router_decode #(
    .ADDRESS_WIDTH  (ADDRESS_WIDTH),
    .SLAVE_ADDR_BITS(SLAVE_ADDR_BITS),
    .NUM_SLAVES     (NUM_SLAVES),
    .SEL_WIDTH      (SEL_WIDTH)
  ) u_decode (
    .addr      (dec_addr),
    .idx       (dec_idx),
    .valid     (dec_valid),
    .local_addr(dec_local)
  );

  always_comb begin
    sel_rack  = 1'b0;
    sel_wack  = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == SEL_WIDTH'(i)) begin
        sel_rack  = m_up_rack[i];
        sel_wack  = m_up_wack[i];
        sel_rdata = m_up_rdata[i*DW +: DW];
      end
    end
    timeout = (cnt >= CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      is_rd      <= 1'b0;
      sel        <= '0;
      cnt        <= '0;
      up_rack    <= 1'b0;
      up_wack    <= 1'b0;
      up_rdata   <= '0;
      err        <= 1'b0;
      m_up_rreq  <= '0;
      m_up_wreq  <= '0;
      m_up_raddr <= '0;
      m_up_waddr <= '0;
      m_up_wdata <= '0;
    end else begin
      up_rack <= 1'b0;
      up_wack <= 1'b0;
      err     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (up_rreq || up_wreq) begin
            is_rd <= up_rreq;
            sel   <= dec_idx;
            cnt   <= '0;
            if (up_rreq) begin
              m_up_raddr <= dec_local;
            end else begin
              m_up_waddr <= dec_local;
              m_up_wdata <= up_wdata;
            end
            if (dec_valid) begin
              if (up_rreq) begin
                m_up_rreq <= NUM_SLAVES'(1) << dec_idx;
                state     <= RD_WAIT;
              end else begin
                m_up_wreq <= NUM_SLAVES'(1) << dec_idx;
                state     <= WR_WAIT;
              end
            end else begin
              err <= 1'b1;
              if (up_rreq) begin
                up_rack  <= 1'b1;
                up_rdata <= ERROR_DATA;
              end else begin
                up_wack  <= 1'b1;
              end
              state <= RESP;
            end
          end
        end
        RD_WAIT: begin
          if (sel_rack || timeout) begin
            m_up_rreq <= '0;
            up_rack   <= 1'b1;
            up_rdata  <= sel_rack ? sel_rdata : ERROR_DATA;
            err       <= !sel_rack;
            state     <= RESP;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        WR_WAIT: begin
          if (sel_wack || timeout) begin
            m_up_wreq <= '0;
            up_wack   <= 1'b1;
            err       <= !sel_wack;
            state     <= RESP;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: state <= HOLD;
        HOLD: begin
          if (is_rd ? !up_rreq : !up_wreq) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_up_router.sv
// Directed self-checking bench for up_router (4 slaves, 256-byte windows, 8-cycle timeout).
module tb_up_router;

  logic        clk;
  logic        rst;
  logic        up_rreq;
  logic        up_rack;
  logic [15:0] up_raddr;
  logic [31:0] up_rdata;
  logic        up_wreq;
  logic        up_wack;
  logic [15:0] up_waddr;
  logic [31:0] up_wdata;
  logic [3:0]  m_up_rreq;
  logic [3:0]  m_up_rack;
  logic [15:0] m_up_raddr;
  logic [127:0] m_up_rdata;
  logic [3:0]  m_up_wreq;
  logic [3:0]  m_up_wack;
  logic [15:0] m_up_waddr;
  logic [31:0] m_up_wdata;
  logic        err;

  int checks;
  int errors;

  up_router #(
    .ADDRESS_WIDTH  (16),
    .BUS_WIDTH      (4),
    .NUM_SLAVES     (4),
    .SLAVE_ADDR_BITS(8),
    .TIMEOUT_CYCLES (8),
    .ERROR_DATA     (32'hDEADBEEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up_rreq   (up_rreq),
    .up_rack   (up_rack),
    .up_raddr  (up_raddr),
    .up_rdata  (up_rdata),
    .up_wreq   (up_wreq),
    .up_wack   (up_wack),
    .up_waddr  (up_waddr),
    .up_wdata  (up_wdata),
    .m_up_rreq (m_up_rreq),
    .m_up_rack (m_up_rack),
    .m_up_raddr(m_up_raddr),
    .m_up_rdata(m_up_rdata),
    .m_up_wreq (m_up_wreq),
    .m_up_wack (m_up_wack),
    .m_up_waddr(m_up_waddr),
    .m_up_wdata(m_up_wdata),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; up_rreq = 0; up_wreq = 0; up_raddr = 0; up_waddr = 0; up_wdata = 0;
    m_up_rack = 0; m_up_wack = 0; m_up_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({up_rack, up_wack, err, m_up_rreq, m_up_wreq} !== 11'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0", {up_rack, up_wack, err, m_up_rreq, m_up_wreq});
    end
    checks++;
    if ({up_rdata, m_up_raddr, m_up_waddr, m_up_wdata} !== 96'b0) begin
      errors++; $display("FAIL reset_data got %h want 0", {up_rdata, m_up_raddr, m_up_waddr, m_up_wdata});
    end
  endtask

  task automatic test_read();
    up_raddr = 16'h0104; up_rreq = 1'b1;
    tick();
    checks++;
    if (m_up_rreq !== 4'b0010) begin errors++; $display("FAIL rd_req got %b want 0010", m_up_rreq); end
    checks++;
    if (m_up_raddr !== 16'h0004) begin errors++; $display("FAIL rd_addr got %h want 0004", m_up_raddr); end
    tick(); tick();
    m_up_rack = 4'b0010; m_up_rdata[32 +: 32] = 32'h41424344;
    checks++;
    if (up_rack !== 1'b0) begin errors++; $display("FAIL rd_early_ack got %b want 0", up_rack); end
    tick();
    m_up_rack = 4'b0000; up_rreq = 1'b0;
    checks++;
    if ({up_rack, err, m_up_rreq} !== 6'b100000) begin
      errors++; $display("FAIL rd_ack got rack/err/req %b want 100000", {up_rack, err, m_up_rreq});
    end
    checks++;
    if (up_rdata !== 32'h41424344) begin errors++; $display("FAIL rd_data got %h want 41424344", up_rdata); end
    tick();
    checks++;
    if (up_rack !== 1'b0) begin errors++; $display("FAIL rd_ack_pulse got %b want 0", up_rack); end
    tick();
  endtask

  task automatic test_write();
    int wacks;
    up_waddr = 16'h0210; up_wdata = 32'hA5A5A5A5; up_wreq = 1'b1;
    tick();
    checks++;
    if (m_up_wreq !== 4'b0100) begin errors++; $display("FAIL wr_req got %b want 0100", m_up_wreq); end
    checks++;
    if ({m_up_waddr, m_up_wdata} !== {16'h0010, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL wr_addr_data got %h want 0010a5a5a5a5", {m_up_waddr, m_up_wdata});
    end
    m_up_wack = 4'b0001;  // wrong slave acks
    tick();
    checks++;
    if ({up_wack, m_up_wreq} !== 5'b00100) begin
      errors++; $display("FAIL wr_ignore_other got %b want 00100", {up_wack, m_up_wreq});
    end
    m_up_wack = 4'b0100;
    wacks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (up_wack) wacks++;
      m_up_wack = 4'b0000;
      if (i == 0) up_wreq = 1'b0;
    end
    checks++;
    if (wacks != 1) begin errors++; $display("FAIL wr_single_ack got %0d want 1", wacks); end
    checks++;
    if (up_rdata !== 32'h41424344) begin errors++; $display("FAIL wr_rdata_kept got %h want 41424344", up_rdata); end
  endtask

  task automatic test_decode_error();
    up_raddr = 16'h0500; up_rreq = 1'b1;
    tick();
    up_rreq = 1'b0;
    checks++;
    if ({up_rack, err, m_up_rreq} !== 6'b110000) begin
      errors++; $display("FAIL dec_err_ack got rack/err/req %b want 110000", {up_rack, err, m_up_rreq});
    end
    checks++;
    if (up_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL dec_err_data got %h want deadbeef", up_rdata); end
    tick();
    checks++;
    if ({up_rack, err} !== 2'b00) begin errors++; $display("FAIL dec_err_pulse got %b want 00", {up_rack, err}); end
    tick();
  endtask

  task automatic test_timeout();
    int high;
    high = 0;
    up_raddr = 16'h0300; up_rreq = 1'b1;
    for (int i = 0; i < 12 && !up_rack; i++) begin
      tick();
      if (m_up_rreq[3]) high++;
    end
    up_rreq = 1'b0;
    checks++;
    if (high != 8) begin errors++; $display("FAIL to_req_cycles got %0d want 8", high); end
    checks++;
    if ({up_rack, err, m_up_rreq} !== 6'b110000) begin
      errors++; $display("FAIL to_ack got rack/err/req %b want 110000", {up_rack, err, m_up_rreq});
    end
    checks++;
    if (up_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL to_data got %h want deadbeef", up_rdata); end
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    up_raddr = 16'h0008; up_waddr = 16'h0120; up_wdata = 32'h12345678;
    up_rreq = 1'b1; up_wreq = 1'b1;
    tick();
    checks++;
    if ({m_up_rreq, m_up_wreq} !== 8'b0001_0000) begin
      errors++; $display("FAIL b2b_rd_first got %b want 00010000", {m_up_rreq, m_up_wreq});
    end
    m_up_rack = 4'b0001; m_up_rdata[0 +: 32] = 32'h11111111;
    tick();
    m_up_rack = 4'b0000; up_rreq = 1'b0;
    checks++;
    if ({up_rack, up_wack, up_rdata} !== {2'b10, 32'h11111111}) begin
      errors++; $display("FAIL b2b_rack got %h want 211111111", {up_rack, up_wack, up_rdata});
    end
    tick(); tick(); tick();
    checks++;
    if ({m_up_rreq, m_up_wreq, m_up_waddr} !== {8'b0000_0010, 16'h0020}) begin
      errors++; $display("FAIL b2b_wr_issue got %h want 020020", {m_up_rreq, m_up_wreq, m_up_waddr});
    end
    m_up_wack = 4'b0010;
    tick();
    m_up_wack = 4'b0000; up_wreq = 1'b0;
    checks++;
    if ({up_rack, up_wack, err} !== 3'b010) begin
      errors++; $display("FAIL b2b_wack got %b want 010", {up_rack, up_wack, err});
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    up_raddr = 16'h0204; up_rreq = 1'b1;
    tick();
    checks++;
    if (m_up_rreq !== 4'b0100) begin errors++; $display("FAIL rst_mid_req got %b want 0100", m_up_rreq); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({m_up_rreq, m_up_wreq, up_rack, up_wack, up_rdata} !== 42'b0) begin
      errors++; $display("FAIL rst_mid_clear got %h want 0", {m_up_rreq, m_up_wreq, up_rack, up_wack, up_rdata});
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (m_up_rreq !== 4'b0100) begin errors++; $display("FAIL rst_after_req got %b want 0100", m_up_rreq); end
    m_up_rack = 4'b0100; m_up_rdata[64 +: 32] = 32'hCAFEF00D;
    tick();
    m_up_rack = 4'b0000; up_rreq = 1'b0;
    checks++;
    if ({up_rack, err, up_rdata} !== {2'b10, 32'hCAFEF00D}) begin
      errors++; $display("FAIL rst_after_ack got %h want 2cafef00d", {up_rack, err, up_rdata});
    end
    tick(); tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_read();
    test_write();
    test_decode_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
